// File: rtl/uart_tx_sched.sv
// Transmit scheduler for a memory-mapped UART: programs baud/control after reset,
// then round-robins core (req 0) and debug (req 1) bytes into the TX data register.
module uart_tx_sched #(
  parameter int          BAUD_DIV      = 103,
  parameter logic [31:0] CTRL_VAL      = 32'h31,
  parameter int          START_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [7:0]  req_data0,
  input  logic [7:0]  req_data1,
  output logic [1:0]  req_ready,
  output logic        init_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [3:0]  uart_addr,
  output logic [31:0] wdata_mem,
  output logic        uart_wr_enable,
  output logic        uart_sel,
  input  logic [31:0] uart_data,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte moves from requester i on a rising edge where
  // req_valid[i] && req_ready[i]; req_ready is one-hot and high for one cycle.

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    INIT_BAUD  = 3'd0,
    INIT_CTRL  = 3'd1,
    IDLE       = 3'd2,
    POLL       = 3'd3,
    WRITE      = 3'd4,
    WAIT_START = 3'd5,
    WAIT_DONE  = 3'd6
  } state_t;

  state_t          state;
  logic            ptr;
  logic [7:0]      tx_byte;
  logic [CW-1:0]   cnt;
  logic [1:0]      pick;
  logic            tx_busy;
  logic            unused_uart_bits;

  assign state_dbg        = state;
  assign tx_busy          = uart_data[0];
  assign unused_uart_bits = ^uart_data[31:1];

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    pick = req_valid;
    if (req_valid == 2'b11) pick = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= INIT_BAUD;
      ptr            <= 1'b0;
      tx_byte        <= 8'h00;
      cnt            <= '0;
      req_ready      <= 2'b00;
      init_done      <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      uart_addr      <= 4'h0;
      wdata_mem      <= 32'h0;
      uart_wr_enable <= 1'b0;
      uart_sel       <= 1'b0;
    end else begin
      case (state)
        INIT_BAUD: begin
          uart_addr      <= 4'hC;
          wdata_mem      <= 32'(BAUD_DIV);
          uart_wr_enable <= 1'b1;
          busy           <= 1'b1;
          state          <= INIT_CTRL;
        end
        INIT_CTRL: begin
          uart_addr      <= 4'h8;
          wdata_mem      <= CTRL_VAL;
          uart_wr_enable <= 1'b1;
          init_done      <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        IDLE: begin
          uart_wr_enable <= 1'b0;
          uart_sel       <= 1'b0;
          uart_addr      <= 4'h0;
          if (req_ready != 2'b00) begin
            // Accept cycle: the offer was made last cycle, transfer happens now.
            req_ready <= 2'b00;
            if (|(req_valid & req_ready)) begin
              tx_byte  <= req_ready[1] ? req_data1 : req_data0;
              ptr      <= req_ready[0];
              uart_sel <= 1'b1;
              busy     <= 1'b1;
              state    <= POLL;
            end
          end else if (|req_valid) begin
            req_ready <= pick;
          end
        end
        POLL: begin
          if (!tx_busy) begin
            uart_sel       <= 1'b0;
            uart_addr      <= 4'h4;
            wdata_mem      <= {24'h0, tx_byte};
            uart_wr_enable <= 1'b1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          uart_wr_enable <= 1'b0;
          uart_sel       <= 1'b1;
          uart_addr      <= 4'h0;
          cnt            <= '0;
          state          <= WAIT_START;
        end
        WAIT_START: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(START_TIMEOUT - 1)) begin
            // UART never started: drop the byte and flag it until reset.
            timeout_err <= 1'b1;
            uart_sel    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            uart_sel <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= INIT_BAUD;
      endcase
    end
  end

endmodule
